// File: rtl/ukf_input_mem_reader.sv
// Streams word_count consecutive memory words from base_address into the input FIFO path.
// A small credit-limited buffer absorbs read latency and FIFO backpressure.
module ukf_input_mem_reader #(
  parameter int DATA_W       = 128,
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1,
  parameter int BUF_DEPTH    = READ_LATENCY + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_address,
  input  logic [ADDR_W:0]     word_count,
  output logic [ADDR_W-1:0]   address,
  output logic                chipselect,
  output logic                clken,
  output logic [DATA_W/8-1:0] byteenable,
  output logic                write,
  input  logic [DATA_W-1:0]   readdata,
  input  logic                fifo_full,
  output logic [DATA_W-1:0]   write_data,
  output logic                wr_enable,
  output logic                busy,
  output logic                done
);

  localparam int BW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam logic [BW-1:0]     LAST_IDX = BW'(BUF_DEPTH - 1);
  localparam logic [BW-1:0]     IDX_ONE  = BW'(1);
  localparam logic [OW-1:0]     OCC_ONE  = OW'(1);
  localparam logic [OW-1:0]     DEPTH_C  = OW'(BUF_DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_W-1:0]     ptr;
  logic [ADDR_W:0]       cnt, issued, written;
  logic [READ_LATENCY:1] vld_pipe;
  logic [DATA_W-1:0]     fbuf [BUF_DEPTH];
  logic [BW-1:0]         rd_idx, wr_idx;
  logic [OW-1:0]         occ, inflight;
  logic                  accept, issue, push, pop, credit_ok;

  always_comb begin
    inflight = '0;
    for (int k = 1; k <= READ_LATENCY; k++)
      inflight = inflight + {{(OW-1){1'b0}}, vld_pipe[k]};
  end

  // A pop in this cycle frees a slot, so back-to-back issue keeps one word per cycle.
  assign credit_ok = ({1'b0, occ} + {1'b0, inflight}) < ({1'b0, DEPTH_C} + {{OW{1'b0}}, pop});
  assign accept    = (state == S_IDLE) && start;
  assign issue     = (state == S_READ) && (issued != cnt) && credit_ok;
  assign push      = vld_pipe[READ_LATENCY];
  assign pop       = (occ != '0) && !fifo_full;

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (word_count == '0) ? S_DONE : S_READ;
      S_READ:  if (issue && (issued + CNT_ONE) == cnt) state_nxt = S_DRAIN;
      S_DRAIN: if ((written + {{ADDR_W{1'b0}}, pop}) == cnt) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    chipselect = issue;
    clken      = (state == S_READ) || (state == S_DRAIN);
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
  end

  assign address    = ptr;
  assign byteenable = {(DATA_W/8){chipselect}};
  assign write      = 1'b0;
  assign wr_enable  = pop;
  assign write_data = fbuf[rd_idx];

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr      <= '0;
      cnt      <= '0;
      issued   <= '0;
      written  <= '0;
      vld_pipe <= '0;
      rd_idx   <= '0;
      wr_idx   <= '0;
      occ      <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) fbuf[i] <= '0;
    end else begin
      if (accept) begin
        ptr     <= base_address;
        cnt     <= word_count;
        issued  <= '0;
        written <= '0;
      end else begin
        if (issue) begin
          ptr    <= ptr + PTR_ONE;
          issued <= issued + CNT_ONE;
        end
        if (pop) written <= written + CNT_ONE;
      end
      vld_pipe[1] <= issue;
      for (int k = 2; k <= READ_LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
      if (push) begin
        fbuf[wr_idx] <= readdata;
        wr_idx       <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IDX_ONE;
      end
      if (pop) rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + IDX_ONE;
      case ({push, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_ukf_input_mem_reader.sv
// Directed bench for ukf_input_mem_reader: cycle-exact transfers, backpressure, wrap, reset, ignored start.
module tb_ukf_input_mem_reader;
  localparam int DW = 128;
  localparam int AW = 10;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [AW-1:0]   base_address = '0;
  logic [AW:0]     word_count = '0;
  logic [AW-1:0]   address;
  logic            chipselect, clken, write, wr_enable, busy, done;
  logic [DW/8-1:0] byteenable;
  logic [DW-1:0]   readdata = '0;
  logic            fifo_full = 1'b0;
  logic [DW-1:0]   write_data;
  logic [DW-1:0]   mem [1024];

  ukf_input_mem_reader dut (
    .clock(clock), .reset(reset), .start(start), .base_address(base_address),
    .word_count(word_count), .address(address), .chipselect(chipselect), .clken(clken),
    .byteenable(byteenable), .write(write), .readdata(readdata), .fifo_full(fifo_full),
    .write_data(write_data), .wr_enable(wr_enable), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // One-cycle registered read memory model.
  always @(posedge clock) if (chipselect && clken) readdata <= mem[address];

  int checks = 0;
  int errors = 0;
  int proto_err = 0;
  int cs_cyc[$], cs_addr[$], wr_cyc[$], done_cyc[$];
  logic [DW-1:0] wr_dat[$];
  logic [63:0]   busy_mask;
  logic [159:0]  snap;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_at(input int a);
    logic [31:0] w;
    w = 32'h1000_0000 + a;
    return {4{w}};
  endfunction

  task automatic sample(input int c);
    if (chipselect) begin cs_cyc.push_back(c); cs_addr.push_back(int'(address)); end
    if (chipselect && byteenable != '1) proto_err++;
    if (!chipselect && byteenable != '0) proto_err++;
    if (write) proto_err++;
    if (wr_enable && fifo_full) proto_err++;
    if (wr_enable) begin wr_cyc.push_back(c); wr_dat.push_back(write_data); end
    if (done) done_cyc.push_back(c);
    if (busy && c < 64) busy_mask[c] = 1'b1;
  endtask

  // mode: 0 plain, 1 full in cycles 3-8, 2 full on odd cycles, 3 second start in cycle 2, 4 reset in cycle 6
  task automatic txn(input int base, input int cnt, input int ncyc, input int mode);
    cs_cyc.delete(); cs_addr.delete(); wr_cyc.delete(); wr_dat.delete(); done_cyc.delete();
    busy_mask = '0;
    for (int c = 0; c < ncyc; c++) begin
      start        = (c == 0) || (mode == 3 && c == 2);
      base_address = (mode == 3 && c == 2) ? AW'(12'h100) : AW'(base);
      word_count   = (mode == 3 && c == 2) ? (AW+1)'(8) : (AW+1)'(cnt);
      fifo_full    = (mode == 1) ? (c >= 3 && c <= 8) : (mode == 2) ? c[0] : 1'b0;
      reset        = !(mode == 4 && c == 6);
      @(negedge clock);
      if (mode == 4 && c == 7)
        snap = {address, chipselect, clken, byteenable, write, wr_enable, write_data, busy, done};
      sample(c);
      @(posedge clock); #1;
    end
    start = 1'b0; fifo_full = 1'b0; reset = 1'b1;
  endtask

  task automatic exp_cs(input string tag, input int base, input int n, input int first);
    chk({tag, ".cs_n"}, cs_addr.size(), n);
    foreach (cs_addr[i]) begin
      chk({tag, ".cs_addr"}, cs_addr[i], (base + i) % 1024);
      if (first >= 0) chk({tag, ".cs_cyc"}, cs_cyc[i], first + i);
    end
  endtask

  task automatic exp_wr(input string tag, input int base, input int n, input int first);
    chk({tag, ".wr_n"}, wr_dat.size(), n);
    foreach (wr_dat[i]) begin
      chk({tag, ".wr_data"}, wr_dat[i], word_at((base + i) % 1024));
      if (first >= 0) chk({tag, ".wr_cyc"}, wr_cyc[i], first + i);
    end
  endtask

  task automatic exp_done(input string tag, input int cyc);
    chk({tag, ".done_n"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk({tag, ".done_cyc"}, done_cyc[0], cyc);
  endtask

  initial begin
    int t2_cs[4];
    t2_cs = '{1, 2, 9, 10};
    for (int i = 0; i < 1024; i++) mem[i] = word_at(i);

    // reset state
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock);
    snap = {address, chipselect, clken, byteenable, write, wr_enable, write_data, busy, done};
    chk("reset_outs", snap, 160'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // basic transfer
    txn(12'h010, 4, 12, 0);
    exp_cs("basic", 12'h010, 4, 1);
    exp_wr("basic", 12'h010, 4, 3);
    exp_done("basic", 7);
    chk("basic.busy", busy_mask, 64'hFE);

    // backpressure in cycles 3-8
    txn(12'h010, 4, 20, 1);
    chk("bp.cs_n", cs_cyc.size(), 4);
    foreach (cs_cyc[i]) if (i < 4) chk("bp.cs_cyc", cs_cyc[i], t2_cs[i]);
    exp_wr("bp", 12'h010, 4, 9);
    exp_done("bp", 13);

    // zero count goes straight to DONE
    txn(12'h055, 0, 6, 0);
    chk("zero.cs_n", cs_cyc.size(), 0);
    chk("zero.wr_n", wr_dat.size(), 0);
    exp_done("zero", 1);
    chk("zero.busy", busy_mask, 64'h2);

    // address wrap
    txn(12'h3FE, 4, 12, 0);
    exp_cs("wrap", 12'h3FE, 4, 1);
    exp_wr("wrap", 12'h3FE, 4, 3);
    exp_done("wrap", 7);

    // reset mid-transfer, then a fresh transfer
    txn(12'h000, 16, 10, 4);
    chk("rst.outs_after", snap, 160'd0);
    chk("rst.no_done", done_cyc.size(), 0);
    txn(12'h020, 2, 8, 0);
    exp_cs("rst2", 12'h020, 2, 1);
    exp_wr("rst2", 12'h020, 2, 3);
    exp_done("rst2", 5);

    // start while busy is ignored
    txn(12'h010, 4, 14, 3);
    exp_cs("busy_start", 12'h010, 4, 1);
    exp_wr("busy_start", 12'h010, 4, 3);
    exp_done("busy_start", 7);

    // fifo_full toggling every cycle
    txn(12'h040, 6, 40, 2);
    exp_wr("toggle", 12'h040, 6, -1);
    chk("toggle.done_n", done_cyc.size(), 1);

    // full memory sweep from a non-zero base
    txn(12'h155, 1024, 1032, 0);
    exp_wr("full", 12'h155, 1024, 3);
    exp_done("full", 1027);

    chk("protocol", proto_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
